tgif_round_seq: RTL
===================

# tgif_round_seq

Round sequencer for the TGIF `mode_top` datapath in 32-bit serial configuration. It accepts a block request, streams key and state words into the datapath over a valid/ready port, then runs TBC rounds until the datapath's round constant reaches its terminal value. It then streams the state back out and signals completion. It sits between the packet-level controller (API/cu32 class) and the datapath, so the packet controller deals only in whole blocks.

## Interface
- `BUSWIDTH`, 32, datapath word width (informational; words are not routed through this block)
- `WORDS`, 4, words per 128-bit state/key load or unload
- `LAST_CONST`, 6'h1A, value of `constant` that marks the final round
- `MAX_ROUNDS`, 64, watchdog limit on RUN cycles

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: block request, honoured only in IDLE
- `key_new` in 1: sampled with `start`; 1 = load a new key before the state
- `pdi_valid` in 1: input word available
- `pdi_ready` out 1: input word accepted this cycle
- `pdo_valid` out 1: output word presented
- `pdo_ready` in 1: output word consumed
- `constant` in 6: current round constant from the datapath
- `srst`, `senc`, `sse` out 1 each: state register clear, round-update enable, word-shift enable
- `xrst`, `xenc`, `xse` out 1 each: key register clear, round-update enable, word-shift enable
- `erst` out 1: round-constant generator reset
- `sl` out 1: state shift source; 1 = pdi word, 0 = recirculate/unload
- `correct_cnt` out 1: one-cycle key-schedule correction pulse
- `busy` out 1, `done` out 1, `fail` out 1: status

## Operation
- FSM states: IDLE, LDKEY, LDST, INIT, RUN, UNLD, DONE, FAIL.
- **IDLE:** `busy`=0.
  - On `start`: assert `srst` and latch `key_new`. Also assert `xrst` if `key_new`.
  - Next state is LDKEY if `key_new`, else LDST.
- **LDKEY:**
  - `pdi_ready`=1.
  - Each cycle with `pdi_valid`: `xse`=1 and the word counter increments.
  - After `WORDS` beats, go to LDST.
- **LDST:**
  - `pdi_ready`=1, `sl`=1.
  - Each beat: `sse`=1.
  - After `WORDS` beats, go to INIT.
- **INIT:** one cycle, `erst`=1, round counter cleared; go to RUN.
- **RUN:**
  - `senc`=`xenc`=1 every cycle; round counter increments.
  - If `constant`==`LAST_CONST` this cycle, that cycle is the final round: pulse `correct_cnt` and go to UNLD.
  - Otherwise, if the round counter reaches `MAX_ROUNDS`-1, go to FAIL.
- **UNLD:**
  - `pdo_valid`=1, `sl`=0.
  - Each beat with `pdo_ready`: `sse`=1.
  - After `WORDS` beats, go to DONE.
- **DONE:** `done`=1 for one cycle; go to IDLE.
- **FAIL:**
  - `fail`=1, held until `rst` or a new `start`.
  - `start` in FAIL behaves as `start` in IDLE: clears `fail` and begins a new block.
- `busy`=1 in every state except IDLE and FAIL.
- Word counter: 2 bits when `WORDS`=4 (width `$clog2(WORDS)`), wraps to 0 on the last beat.
- Round counter: 7 bits, saturates.
- `start` while busy is ignored.
- `key_new` is ignored outside the `start` cycle.

## Timing
- Reset value of every output is 0; the FSM is in IDLE one edge after `rst`.
- `rst` mid-operation aborts at the next edge with no partial `done`, and the datapath is not cleared. The first `start` afterwards asserts `srst` (and `xrst` if `key_new`=1).
- Strobes (`srst`, `xrst`, `erst`, `correct_cnt`, `done`) are one cycle wide and combinationally decoded from the state plus handshake.
- `pdi_ready` is asserted independently of `pdi_valid`.
- `pdo_valid`, once asserted, stays high until the beat completes.
- No bubbles between transitions: cycles with `pdi_valid`=0 or `pdo_ready`=0 stall without a shift.
- Minimum latency from `start` to `done`, with full-rate handshakes and R RUN cycles: 1 + 4·`key_new` + 4 + 1 + R + 4 + 1 cycles.
- If `LAST_CONST` is seen on the first RUN cycle, R=1 and `correct_cnt` fires in that cycle.
- `constant`==`LAST_CONST` and the watchdog limit in the same cycle: `LAST_CONST` wins and the block completes normally.

## Structure
- The shared package `tgif_pkg` holds:
  - the FSM state enum;
  - default `LAST_CONST`;
  - `WORDS`;
  - `MAX_ROUNDS`.
- One sub-module, `tgif_beat_cnt`: word counter with enable, wrap and `last` flag. It is instantiated once and shared by LDKEY, LDST and UNLD.
- The round counter and FSM stay inline.

## Test plan
- `start`, `key_new`=1, `pdi_valid` held high; `constant` model reaches 6'h1A after 40 RUN cycles → exactly 4 `xse`, then 4 `sse` with `sl`=1, one `erst`, 40 `senc`, `correct_cnt` on RUN cycle 40, 4 UNLD beats, `done` at cycle 54.
- `key_new`=0, `pdi_valid` toggling 1010… → `sse` only on valid cycles, no `xse` or `xrst`; LDST takes 8 cycles.
- `pdo_ready` low for 3 cycles mid-UNLD → `pdo_valid` stays high, no `sse` while stalled; `done` delayed by 3 cycles.
- `constant` never equals 6'h1A → `fail`=1 after 64 RUN cycles with `busy`=0; the next `start` clears `fail` and runs normally.
- `rst` pulsed during RUN cycle 10 → all outputs 0 on the next edge; a subsequent `start` with `key_new`=1 asserts `srst` and `xrst`.
- `start` pulsed during LDST → ignored; word count and `done` timing unchanged.

Source files
------------

// File: rtl/tgif_pkg.sv
// Shared definitions for the TGIF round sequencer: FSM state encoding and
// default block geometry / termination constants.
package tgif_pkg;

  localparam int         WORDS      = 4;
  localparam int         MAX_ROUNDS = 64;
  localparam logic [5:0] LAST_CONST = 6'h1A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LDKEY = 3'd1,
    ST_LDST  = 3'd2,
    ST_INIT  = 3'd3,
    ST_RUN   = 3'd4,
    ST_UNLD  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } state_e;

endpackage

// File: rtl/tgif_beat_cnt.sv
// Word-beat counter shared by the key load, state load and unload phases;
// wraps to zero on the beat that completes a block of WORDS words.
module tgif_beat_cnt
  import tgif_pkg::*;
#(
  parameter int WORDS = tgif_pkg::WORDS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_last
);

  localparam int            CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  logic [CW-1:0] r_cnt;

  // beat counter, advanced once per completed handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST_IDX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/tgif_round_seq.sv
// Round sequencer for the TGIF 32-bit serial datapath: loads key/state words,
// runs rounds until the terminal round constant, then unloads the state.
module tgif_round_seq
  import tgif_pkg::*;
#(
  parameter int         WORDS      = tgif_pkg::WORDS,
  parameter logic [5:0] LAST_CONST = tgif_pkg::LAST_CONST,
  parameter int         MAX_ROUNDS = tgif_pkg::MAX_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_new,
  input  logic       pdi_valid,
  output logic       pdi_ready,
  output logic       pdo_valid,
  input  logic       pdo_ready,
  input  logic [5:0] constant,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       erst,
  output logic       sl,
  output logic       correct_cnt,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [6:0] RND_SAT  = 7'h7F;
  localparam logic [6:0] RND_LAST = 7'(MAX_ROUNDS - 1);

  state_e     r_state;
  state_e     w_next;
  logic [6:0] r_round;
  logic       w_beat;
  logic       w_last;

  tgif_beat_cnt #(.WORDS(WORDS)) u_beat (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_beat),
    .o_last (w_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // round counter: cleared in INIT, saturating count of RUN cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= 7'd0;
    end else if (r_state == ST_INIT) begin
      r_round <= 7'd0;
    end else if ((r_state == ST_RUN) && (r_round != RND_SAT)) begin
      r_round <= r_round + 7'd1;
    end else begin
      r_round <= r_round;
    end
  end

  // next-state and strobe decode
  always_comb begin
    w_next      = r_state;
    w_beat      = 1'b0;
    pdi_ready   = 1'b0;
    pdo_valid   = 1'b0;
    srst        = 1'b0;
    senc        = 1'b0;
    sse         = 1'b0;
    xrst        = 1'b0;
    xenc        = 1'b0;
    xse         = 1'b0;
    erst        = 1'b0;
    sl          = 1'b0;
    correct_cnt = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fail        = 1'b0;
    case (r_state)
      ST_IDLE, ST_FAIL: begin
        fail = (r_state == ST_FAIL);
        if (start) begin
          srst   = 1'b1;
          xrst   = key_new;
          w_next = key_new ? ST_LDKEY : ST_LDST;
        end else begin
          w_next = r_state;
        end
      end
      ST_LDKEY: begin
        busy      = 1'b1;
        pdi_ready = 1'b1;
        if (pdi_valid) begin
          xse    = 1'b1;
          w_beat = 1'b1;
          w_next = w_last ? ST_LDST : ST_LDKEY;
        end else begin
          w_next = ST_LDKEY;
        end
      end
      ST_LDST: begin
        busy      = 1'b1;
        pdi_ready = 1'b1;
        sl        = 1'b1;
        if (pdi_valid) begin
          sse    = 1'b1;
          w_beat = 1'b1;
          w_next = w_last ? ST_INIT : ST_LDST;
        end else begin
          w_next = ST_LDST;
        end
      end
      ST_INIT: begin
        busy   = 1'b1;
        erst   = 1'b1;
        w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        senc = 1'b1;
        xenc = 1'b1;
        // the terminal constant takes priority over the watchdog
        if (constant == LAST_CONST) begin
          correct_cnt = 1'b1;
          w_next      = ST_UNLD;
        end else if (r_round == RND_LAST) begin
          w_next = ST_FAIL;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_UNLD: begin
        busy      = 1'b1;
        pdo_valid = 1'b1;
        if (pdo_ready) begin
          sse    = 1'b1;
          w_beat = 1'b1;
          w_next = w_last ? ST_DONE : ST_UNLD;
        end else begin
          w_next = ST_UNLD;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
